tron_tick_ctrl: RTL and testbench

Per-frame game sequencer for the Tron playfield. On each frame tick it advances both cycle heads one cell and checks the new cells against the shared trace RAM. It then either commits both new trace cells or declares game over with a winner. It is the sole owner of the trace RAM port during play and also clears the RAM when a game starts.

---
 rtl/tron_tick_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_tron_tick_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tron_tick_ctrl.sv
// tron_tick_ctrl: per-frame game sequencer for the Tron playfield.
// On each frame tick it advances both cycle heads one cell, reads the new cells
// from the shared trace RAM, then either commits both traces or ends the game.
// It also clears the trace RAM at the start of each game.
// Optional build macro: TRON_WRAP_EN (playfield edges wrap instead of crashing).
module tron_tick_ctrl #(
  parameter int GRID_W  = 200,
  parameter int GRID_H  = 150,
  parameter int P1_X0   = 50,
  parameter int P2_X0   = 149,
  parameter int START_Y = 75,
  parameter int ADDR_W  = 15
) (
  input  logic              clock,
  input  logic              reset_L,
  input  logic              start,
  input  logic              tick,
  input  logic [1:0]        p1_dir,
  input  logic [1:0]        p2_dir,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_wdata,
  input  logic [1:0]        mem_rdata,
  output logic [7:0]        p1_x,
  output logic [7:0]        p2_x,
  output logic [7:0]        p1_y,
  output logic [7:0]        p2_y,
  output logic              busy,
  output logic              game_over,
  output logic [1:0]        winner,
  output logic              tick_missed
);

  localparam int CELLS = GRID_W * GRID_H;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_INIT1, S_INIT2, S_PLAY,
    S_RD1, S_RD2, S_CHECK, S_WR1, S_WR2, S_OVER
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  // Signed 9-bit coordinate so that -1 and GRID_W are representable.
  typedef logic signed [8:0] coord_t;

  state_t            state, state_next;
  dir_t              p1_hdg, p2_hdg;          // committed headings
  dir_t              p1_hdg_cand, p2_hdg_cand; // headings latched on tick
  dir_t              p1_hdg_req, p2_hdg_req;   // requested heading after reversal filter
  coord_t            p1_cx, p1_cy, p2_cx, p2_cy; // candidate heads
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] p1_addr, p2_addr;
  logic [1:0]        p1_data;
  logic              p1_oob, p2_oob, same_cell;
  logic              p1_crash, p2_crash;

  // A request for the exact opposite of the current heading is ignored.
  function automatic dir_t eff_heading(input dir_t cur, input logic [1:0] req);
    if (req == (cur ^ 2'b10)) return cur;
    return dir_t'(req);
  endfunction

  function automatic coord_t delta_x(input dir_t d);
    case (d)
      DIR_RIGHT: return 9'sd1;
      DIR_LEFT:  return -9'sd1;
      default:   return 9'sd0;
    endcase
  endfunction

  function automatic coord_t delta_y(input dir_t d);
    case (d)
      DIR_DOWN: return 9'sd1;
      DIR_UP:   return -9'sd1;
      default:  return 9'sd0;
    endcase
  endfunction

  function automatic coord_t step_x(input coord_t pos, input coord_t delta);
    coord_t r;
    r = pos + delta;
`ifdef TRON_WRAP_EN
    if (r < 9'sd0) r = coord_t'(GRID_W - 1);
    else if (r >= coord_t'(GRID_W)) r = 9'sd0;
`endif
    return r;
  endfunction

  function automatic coord_t step_y(input coord_t pos, input coord_t delta);
    coord_t r;
    r = pos + delta;
`ifdef TRON_WRAP_EN
    if (r < 9'sd0) r = coord_t'(GRID_H - 1);
    else if (r >= coord_t'(GRID_H)) r = 9'sd0;
`endif
    return r;
  endfunction

  function automatic logic out_of_bounds(input coord_t x, input coord_t y);
    return (x < 9'sd0) || (x >= coord_t'(GRID_W)) ||
           (y < 9'sd0) || (y >= coord_t'(GRID_H));
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input coord_t x, input coord_t y);
    return ADDR_W'($unsigned(y)) * ADDR_W'(GRID_W) + ADDR_W'($unsigned(x));
  endfunction

  assign p1_hdg_req = eff_heading(p1_hdg, p1_dir);
  assign p2_hdg_req = eff_heading(p2_hdg, p2_dir);
  assign p1_addr    = cell_addr(p1_cx, p1_cy);
  assign p2_addr    = cell_addr(p2_cx, p2_cy);
  assign p1_oob     = out_of_bounds(p1_cx, p1_cy);
  assign p2_oob     = out_of_bounds(p2_cx, p2_cy);
  assign same_cell  = (p1_cx == p2_cx) && (p1_cy == p2_cy);
  // Read data of an out-of-bounds candidate is never looked at: oob alone decides.
  // P2 data arrives in CHECK, so it is used straight from the RAM port.
  assign p1_crash   = p1_oob || (p1_data != 2'b00) || same_cell;
  assign p2_crash   = p2_oob || (mem_rdata != 2'b00) || same_cell;
  assign game_over  = (state == S_OVER);

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state and RAM port decode; start overrides every state.
  // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 2'b00;
    busy       = 1'b1;
    case (state)
      S_IDLE: busy = 1'b0;
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_addr;
        if (clr_addr == ADDR_W'(CELLS - 1)) state_next = S_INIT1;
      end
      S_INIT1: begin
        mem_we     = 1'b1;
        mem_addr   = cell_addr(coord_t'(P1_X0), coord_t'(START_Y));
        mem_wdata  = 2'b01;
        state_next = S_INIT2;
      end
      S_INIT2: begin
        mem_we     = 1'b1;
        mem_addr   = cell_addr(coord_t'(P2_X0), coord_t'(START_Y));
        mem_wdata  = 2'b10;
        state_next = S_PLAY;
      end
      S_PLAY: begin
        busy = 1'b0;
        if (tick) state_next = S_RD1;
      end
      S_RD1: begin
        mem_re     = !p1_oob;
        mem_addr   = p1_oob ? '0 : p1_addr;
        state_next = S_RD2;
      end
      S_RD2: begin
        mem_re     = !p2_oob;
        mem_addr   = p2_oob ? '0 : p2_addr;
        state_next = S_CHECK;
      end
      S_CHECK: state_next = (p1_crash || p2_crash) ? S_OVER : S_WR1;
      S_WR1: begin
        mem_we     = 1'b1;
        mem_addr   = p1_addr;
        mem_wdata  = 2'b01;
        state_next = S_WR2;
      end
      S_WR2: begin
        mem_we     = 1'b1;
        mem_addr   = p2_addr;
        mem_wdata  = 2'b10;
        state_next = S_PLAY;
      end
      S_OVER: busy = 1'b0;
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
    if (start) state_next = S_CLEAR;
  end

  // Game datapath: clear counter, candidates, captured read data, heads, winner.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      tick_missed <= 1'b0;
      winner      <= 2'b00;
      clr_addr    <= '0;
      p1_data     <= 2'b00;
      p1_x        <= 8'(P1_X0);
      p2_x        <= 8'(P2_X0);
      p1_y        <= 8'(START_Y);
      p2_y        <= 8'(START_Y);
      p1_hdg      <= DIR_RIGHT;
      p2_hdg      <= DIR_LEFT;
      p1_hdg_cand <= DIR_RIGHT;
      p2_hdg_cand <= DIR_LEFT;
      p1_cx       <= '0;
      p1_cy       <= '0;
      p2_cx       <= '0;
      p2_cy       <= '0;
    end else begin
      // A tick that collides with start is swallowed silently.
      tick_missed <= tick && busy && !start;
      if (start) begin
        winner   <= 2'b00;
        clr_addr <= '0;
        p1_x     <= 8'(P1_X0);
        p2_x     <= 8'(P2_X0);
        p1_y     <= 8'(START_Y);
        p2_y     <= 8'(START_Y);
        p1_hdg   <= DIR_RIGHT;
        p2_hdg   <= DIR_LEFT;
      end else begin
        case (state)
          S_CLEAR: clr_addr <= clr_addr + ADDR_W'(1);
          S_PLAY: if (tick) begin
            p1_hdg_cand <= p1_hdg_req;
            p2_hdg_cand <= p2_hdg_req;
            p1_cx <= step_x($signed({1'b0, p1_x}), delta_x(p1_hdg_req));
            p1_cy <= step_y($signed({1'b0, p1_y}), delta_y(p1_hdg_req));
            p2_cx <= step_x($signed({1'b0, p2_x}), delta_x(p2_hdg_req));
            p2_cy <= step_y($signed({1'b0, p2_y}), delta_y(p2_hdg_req));
          end
          S_RD2: p1_data <= mem_rdata;
          S_CHECK: if (p1_crash || p2_crash) winner <= {p1_crash, p2_crash};
          S_WR2: begin
            p1_x   <= p1_cx[7:0];
            p1_y   <= p1_cy[7:0];
            p2_x   <= p2_cx[7:0];
            p2_y   <= p2_cy[7:0];
            p1_hdg <= p1_hdg_cand;
            p2_hdg <= p2_hdg_cand;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tron_tick_ctrl.sv
// Bench for tron_tick_ctrl: one full-size instance (clear sequence, moves,
// reversal, missed tick, wall crash) and one small-grid instance (head-on
// same-cell crash, crash into a trace, start colliding with tick).
module tb_tron_tick_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_L, start_a, start_b, tick;
  logic [1:0] p1_dir, p2_dir;

  // Full-size instance
  logic        a_we, a_re, a_busy, a_go, a_missed;
  logic [14:0] a_addr;
  logic [1:0]  a_wdata, a_win;
  logic [1:0]  a_rdata = 2'b00;
  logic [7:0]  a_p1x, a_p1y, a_p2x, a_p2y;

  // Small 10x8 instance
  logic        b_we, b_re, b_busy, b_go, b_missed;
  logic [6:0]  b_addr;
  logic [1:0]  b_wdata, b_win;
  logic [1:0]  b_rdata = 2'b00;
  logic [7:0]  b_p1x, b_p1y, b_p2x, b_p2y;

  tron_tick_ctrl dut_a (
    .clock(clock), .reset_L(reset_L), .start(start_a), .tick(tick),
    .p1_dir(p1_dir), .p2_dir(p2_dir),
    .mem_we(a_we), .mem_re(a_re), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_rdata(a_rdata),
    .p1_x(a_p1x), .p2_x(a_p2x), .p1_y(a_p1y), .p2_y(a_p2y),
    .busy(a_busy), .game_over(a_go), .winner(a_win), .tick_missed(a_missed)
  );

  tron_tick_ctrl #(
    .GRID_W(10), .GRID_H(8), .P1_X0(2), .P2_X0(6), .START_Y(4), .ADDR_W(7)
  ) dut_b (
    .clock(clock), .reset_L(reset_L), .start(start_b), .tick(tick),
    .p1_dir(p1_dir), .p2_dir(p2_dir),
    .mem_we(b_we), .mem_re(b_re), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_rdata(b_rdata),
    .p1_x(b_p1x), .p2_x(b_p2x), .p1_y(b_p1y), .p2_y(b_p2y),
    .busy(b_busy), .game_over(b_go), .winner(b_win), .tick_missed(b_missed)
  );

  // Trace RAM models: write on clock, read data valid one cycle after mem_re.
  logic [1:0] ram_a [0:29999];
  logic [1:0] ram_b [0:79];
  always @(posedge clock) begin
    if (a_we) ram_a[a_addr] <= a_wdata;
    if (a_re) a_rdata <= ram_a[a_addr];
    if (b_we) ram_b[b_addr] <= b_wdata;
    if (b_re) b_rdata <= ram_b[b_addr];
  end

  // Port rule monitor: never both enables, address 0 when idle.
  int bus_viol = 0;
  always @(negedge clock) begin
    if (reset_L) begin
      if (a_we && a_re) bus_viol++;
      if (!a_we && !a_re && a_addr != 15'd0) bus_viol++;
      if (b_we && b_re) bus_viol++;
      if (!b_we && !b_re && b_addr != 7'd0) bus_viol++;
    end
  end

  // Observation mux: sel=0 full-size, sel=1 small.
  bit          sel = 1'b0;
  logic        m_we, m_re, m_busy, m_go, m_missed;
  logic [14:0] m_addr;
  logic [1:0]  m_wdata, m_win;
  logic [7:0]  m_p1x, m_p1y, m_p2x, m_p2y;
  assign m_we     = sel ? b_we : a_we;
  assign m_re     = sel ? b_re : a_re;
  assign m_busy   = sel ? b_busy : a_busy;
  assign m_go     = sel ? b_go : a_go;
  assign m_missed = sel ? b_missed : a_missed;
  assign m_addr   = sel ? {8'd0, b_addr} : a_addr;
  assign m_wdata  = sel ? b_wdata : a_wdata;
  assign m_win    = sel ? b_win : a_win;
  assign m_p1x    = sel ? b_p1x : a_p1x;
  assign m_p1y    = sel ? b_p1y : a_p1y;
  assign m_p2x    = sel ? b_p2x : a_p2x;
  assign m_p2y    = sel ? b_p2y : a_p2y;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        re1, missed1, missed3, missed4, we4, we5;
    logic [14:0] ra1, a4, a5;
    logic [1:0]  w4, w5;
  } frame_obs_t;

  typedef struct {
    logic [1:0]  d1, d2;
    bit          extra;            // second tick two cycles after the first
    logic [7:0]  p1x, p1y, p2x, p2y;
    bit          wr;               // frame commits both traces
    logic [14:0] a1, a2;
    bit          go;
    logic [1:0]  win;
  } vec_t;

  // One frame: tick at k=0, RD1 k=1, RD2 k=2, CHECK k=3, WR1 k=4, WR2 k=5.
  task automatic run_frame(input logic [1:0] d1, input logic [1:0] d2, input bit extra,
                           output frame_obs_t o);
    p1_dir = d1; p2_dir = d2; tick = 1'b1;
    step(); tick = 1'b0;
    o.re1 = m_re; o.ra1 = m_addr; o.missed1 = m_missed;
    step();
    if (extra) tick = 1'b1;
    step(); tick = 1'b0;
    o.missed3 = m_missed;
    step();
    o.we4 = m_we; o.a4 = m_addr; o.w4 = m_wdata; o.missed4 = m_missed;
    step();
    o.we5 = m_we; o.a5 = m_addr; o.w5 = m_wdata;
    step();
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    frame_obs_t o;
    run_frame(v.d1, v.d2, v.extra, o);
    check({tag, " missed_on_accept"}, o.missed1, 1'b0);
    check({tag, " missed_pulse"}, o.missed3, v.extra);
    if (v.extra) check({tag, " missed_one_cycle"}, o.missed4, 1'b0);
    check({tag, " we_wr1"}, o.we4, v.wr);
    check({tag, " we_wr2"}, o.we5, v.wr);
    if (v.wr) begin
      check({tag, " addr_wr1"}, o.a4, v.a1);
      check({tag, " data_wr1"}, o.w4, 2'b01);
      check({tag, " addr_wr2"}, o.a5, v.a2);
      check({tag, " data_wr2"}, o.w5, 2'b10);
    end
    check({tag, " p1_x"}, m_p1x, v.p1x);
    check({tag, " p1_y"}, m_p1y, v.p1y);
    check({tag, " p2_x"}, m_p2x, v.p2x);
    check({tag, " p2_y"}, m_p2y, v.p2y);
    check({tag, " game_over"}, m_go, v.go);
    check({tag, " winner"}, m_win, v.win);
    check({tag, " busy"}, m_busy, 1'b0);
  endtask

  // Counts busy cycles from the current sample point; bounded.
  task automatic wait_ready(input string name, input int exp_cycles);
    int n = 0;
    while (m_busy && n < 40000) begin
      step();
      n++;
    end
    check(name, n, exp_cycles);
  endtask

  vec_t main_v [3];
  vec_t head_v [3];
  vec_t trace_v[4];

  initial begin
    frame_obs_t o;
    int bad;

    //           d1    d2    ext   p1x    p1y    p2x     p2y    wr    a1         a2         go    win
    main_v[0] = '{2'd1, 2'd3, 1'b0, 8'd51, 8'd75, 8'd148, 8'd75, 1'b1, 15'd15051, 15'd15148, 1'b0, 2'd0};
    main_v[1] = '{2'd3, 2'd3, 1'b0, 8'd52, 8'd75, 8'd147, 8'd75, 1'b1, 15'd15052, 15'd15147, 1'b0, 2'd0};
    main_v[2] = '{2'd0, 2'd3, 1'b1, 8'd52, 8'd74, 8'd146, 8'd75, 1'b1, 15'd14852, 15'd15146, 1'b0, 2'd0};
    // Small grid: P1 (2,4) right, P2 (6,4) left.
    head_v[0]  = '{2'd1, 2'd0, 1'b0, 8'd3, 8'd4, 8'd6, 8'd3, 1'b1, 15'd43, 15'd36, 1'b0, 2'd0};
    head_v[1]  = '{2'd0, 2'd3, 1'b0, 8'd3, 8'd3, 8'd5, 8'd3, 1'b1, 15'd33, 15'd35, 1'b0, 2'd0};
    head_v[2]  = '{2'd1, 2'd3, 1'b0, 8'd3, 8'd3, 8'd5, 8'd3, 1'b0, 15'd0,  15'd0,  1'b1, 2'd3};
    trace_v[0] = '{2'd0, 2'd3, 1'b0, 8'd2, 8'd3, 8'd5, 8'd4, 1'b1, 15'd32, 15'd45, 1'b0, 2'd0};
    trace_v[1] = '{2'd0, 2'd3, 1'b0, 8'd2, 8'd2, 8'd4, 8'd4, 1'b1, 15'd22, 15'd44, 1'b0, 2'd0};
    trace_v[2] = '{2'd0, 2'd3, 1'b0, 8'd2, 8'd1, 8'd3, 8'd4, 1'b1, 15'd12, 15'd43, 1'b0, 2'd0};
    trace_v[3] = '{2'd1, 2'd3, 1'b0, 8'd2, 8'd1, 8'd3, 8'd4, 1'b0, 15'd0,  15'd0,  1'b1, 2'd1};

    reset_L = 1'b0; start_a = 1'b0; start_b = 1'b0; tick = 1'b0;
    p1_dir = 2'd0; p2_dir = 2'd0;
    step(); step();
    check("rst busy", m_busy, 1'b0);
    check("rst game_over", m_go, 1'b0);
    check("rst winner", m_win, 2'd0);
    check("rst mem_we", m_we, 1'b0);
    check("rst mem_re", m_re, 1'b0);
    check("rst mem_addr", m_addr, 15'd0);
    check("rst tick_missed", m_missed, 1'b0);
    check("rst p1_x", m_p1x, 8'd50);
    check("rst p2_x", m_p2x, 8'd149);
    check("rst p1_y", m_p1y, 8'd75);
    reset_L = 1'b1;
    step();

    // Tick in IDLE is ignored and not reported as missed.
    tick = 1'b1; step(); tick = 1'b0;
    check("idle tick busy", m_busy, 1'b0);
    check("idle tick missed", m_missed, 1'b0);
    check("idle tick mem_re", m_re, 1'b0);

    // Clear sequence on the full-size grid.
    start_a = 1'b1; step(); start_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 30000; i++) begin
      if (!(m_busy === 1'b1 && m_we === 1'b1 && m_re === 1'b0 &&
            m_addr === 15'(i) && m_wdata === 2'b00)) bad++;
      step();
    end
    check("clear_sequence_errors", bad, 0);
    check("init1 we", m_we, 1'b1);
    check("init1 addr", m_addr, 15'd15050);
    check("init1 data", m_wdata, 2'b01);
    check("init1 busy", m_busy, 1'b1);
    step();
    check("init2 addr", m_addr, 15'd15149);
    check("init2 data", m_wdata, 2'b10);
    check("init2 busy", m_busy, 1'b1);
    step();
    check("play busy", m_busy, 1'b0);
    check("play we", m_we, 1'b0);

    for (int i = 0; i < 3; i++) apply_vec($sformatf("main%0d", i), main_v[i]);

    // P1 keeps going up until it sits on row 0; P2 keeps heading left.
    bad = 0;
    for (int n = 2; n <= 75; n++) begin
      run_frame(2'd0, 2'd3, 1'b0, o);
      if (m_p1y !== 8'(75 - n) || m_p1x !== 8'd52 || m_p2x !== 8'(147 - n) ||
          o.we4 !== 1'b1 || o.a4 !== 15'((75 - n) * 200 + 52) ||
          o.we5 !== 1'b1 || o.a5 !== 15'(75 * 200 + 147 - n) || m_go !== 1'b0) bad++;
    end
    check("up_run_errors", bad, 0);
    check("up_run p1_y", m_p1y, 8'd0);
    check("up_run p2_x", m_p2x, 8'd72);

    // Tick 76: P1 leaves the top edge.
    run_frame(2'd0, 2'd3, 1'b0, o);
    check("wall oob mem_re", o.re1, 1'b0);
    check("wall oob mem_addr", o.ra1, 15'd0);
    check("wall no write1", o.we4, 1'b0);
    check("wall no write2", o.we5, 1'b0);
    check("wall game_over", m_go, 1'b1);
    check("wall winner", m_win, 2'b10);
    check("wall p1_y held", m_p1y, 8'd0);
    check("wall p2_x held", m_p2x, 8'd72);

    // OVER ignores tick.
    tick = 1'b1; step(); tick = 1'b0;
    check("over tick mem_re", m_re, 1'b0);
    check("over tick missed", m_missed, 1'b0);
    step();
    check("over held game_over", m_go, 1'b1);
    check("over held winner", m_win, 2'b10);

    // Small grid: head-on into the same cell.
    sel = 1'b1;
    start_b = 1'b1; step(); start_b = 1'b0;
    wait_ready("small clear span", 82);
    for (int i = 0; i < 3; i++) apply_vec($sformatf("head%0d", i), head_v[i]);

    // Restart from OVER, then start collides with tick mid-clear.
    start_b = 1'b1; step(); start_b = 1'b0;
    check("restart game_over cleared", m_go, 1'b0);
    check("restart winner cleared", m_win, 2'd0);
    for (int i = 0; i < 9; i++) step();
    check("clear addr before restart", m_addr, 15'd9);
    start_b = 1'b1; tick = 1'b1; step(); start_b = 1'b0; tick = 1'b0;
    check("start+tick clear restarts", m_addr, 15'd0);
    check("start+tick no missed", m_missed, 1'b0);
    wait_ready("restart clear span", 82);

    // P2 runs into P1's start trace.
    for (int i = 0; i < 4; i++) apply_vec($sformatf("trace%0d", i), trace_v[i]);

    check("bus_rule_violations", bus_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
